// File: rtl/packet_injector.sv
// Frames host bytes into header/payload/checksum packets and buffers them in a
// small first-word-fall-through FIFO toward switch rank 0.
module packet_injector #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  err_hdr,
    output logic [7:0]            pkt_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;

    state_t                state, state_nxt;
    logic [2:0]            remain, remain_nxt;
    logic [DATA_WIDTH-1:0] csum, csum_nxt;
    logic                  err_nxt;
    logic                  pkt_inc;
    logic                  push;
    logic [DATA_WIDTH:0]   push_word;
    logic                  pop;
    logic                  xfer;
    logic                  full;
    logic                  empty;

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occ;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (occ == CNT_W'(DEPTH));
    assign empty     = (occ == '0);
    assign in_ready  = !full && (state != TRAILER) && rst_n;
    assign xfer      = in_valid && in_ready;
    assign pop       = !empty && out_ready;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr][DATA_WIDTH-1:0];
    assign out_last  = empty ? 1'b0 : mem[rd_ptr][DATA_WIDTH];

    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        csum_nxt   = csum;
        err_nxt    = 1'b0;
        pkt_inc    = 1'b0;
        push       = 1'b0;
        push_word  = '0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (in_data[5:3] == 3'b000) begin
                        push       = 1'b1;
                        push_word  = {1'b0, in_data};
                        csum_nxt   = in_data;
                        remain_nxt = in_data[2:0];
                        state_nxt  = PAYLOAD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    push      = 1'b1;
                    push_word = {1'b0, in_data};
                    csum_nxt  = csum ^ in_data;
                    if (remain != 3'd0) begin
                        remain_nxt = remain - 3'd1;
                    end else begin
                        state_nxt = TRAILER;
                    end
                end
            end
            TRAILER: begin
                // Checksum waits here until there is room; no bypass through a full FIFO.
                if (!full) begin
                    push      = 1'b1;
                    push_word = {1'b1, csum};
                    pkt_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remain    <= '0;
            csum      <= '0;
            err_hdr   <= 1'b0;
            pkt_count <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
        end else begin
            state   <= state_nxt;
            remain  <= remain_nxt;
            csum    <= csum_nxt;
            err_hdr <= err_nxt;
            if (pkt_inc) begin
                pkt_count <= pkt_count + 8'd1;
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage is not reset; the output mux hides stale entries while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

endmodule
